// File: rtl/gemm_tile_mac.sv
// gemm_tile_mac -- output-stationary GEMM tile multiply-accumulate engine.
//
// Accumulates C[TileM][TileN] += A[TileM][TileK] * B[TileK][TileN] once per
// accepted K-beat, for num_steps beats, then offers the tile on the result
// port. Every accumulate saturates to OutDataWidth (signed or unsigned,
// selected at start). Any clamp raises a sticky overflow flag for the tile.
//
// Handshake semantics (both ports): a transfer happens on a rising edge
// where valid and ready are both 1. The producer holds its data stable
// while valid is high. in_ready_o depends only on state, never on
// in_valid_i. c_valid_o depends only on state, never on c_ready_i.
//
// Ports:
//   clk_i, rst_i      clock; synchronous active-high reset
//   start_i           tile start request, honoured in IDLE only
//   num_steps_i       K-beats to accumulate, latched on start
//   signed_i          1 = signed operands/saturation, latched on start
//   in_valid_i/in_ready_o   A/B beat handshake
//   a_data_i, b_data_i      A and B sub-tiles for one beat
//   c_valid_o/c_ready_i     result handshake
//   c_data_o          accumulator registers (meaningful while c_valid_o=1)
//   busy_o            high whenever the FSM is not in IDLE
//   overflow_o        sticky per-tile saturation flag
//   dbg_state_o       current FSM state (0 IDLE, 1 ACC, 2 DONE)
module gemm_tile_mac #(
  parameter int InDataWidth  = 8,
  parameter int OutDataWidth = 32,
  parameter int TileM        = 4,
  parameter int TileN        = 4,
  parameter int TileK        = 4,
  parameter int CntWidth     = 16
) (
  input  logic                                            clk_i,
  input  logic                                            rst_i,
  input  logic                                            start_i,
  input  logic [CntWidth-1:0]                             num_steps_i,
  input  logic                                            signed_i,
  input  logic                                            in_valid_i,
  output logic                                            in_ready_o,
  input  logic [TileM-1:0][TileK-1:0][InDataWidth-1:0]    a_data_i,
  input  logic [TileK-1:0][TileN-1:0][InDataWidth-1:0]    b_data_i,
  output logic                                            c_valid_o,
  input  logic                                            c_ready_i,
  output logic [TileM-1:0][TileN-1:0][OutDataWidth-1:0]   c_data_o,
  output logic                                            busy_o,
  output logic                                            overflow_o,
  output logic [1:0]                                      dbg_state_o
);

  // Internal sum width: the accumulator plus TileK full products, with a
  // spare sign bit, so the K-sum and the add never lose information.
  localparam int WideW = OutDataWidth + 2 * InDataWidth + $clog2(TileK + 1) + 2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAcc  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Clamp bounds in the wide domain and their OutDataWidth-bit images.
  localparam logic signed [WideW-1:0] SMaxW =
    {{(WideW - OutDataWidth + 1){1'b0}}, {(OutDataWidth - 1){1'b1}}};
  localparam logic signed [WideW-1:0] SMinW =
    {{(WideW - OutDataWidth + 1){1'b1}}, {(OutDataWidth - 1){1'b0}}};
  localparam logic signed [WideW-1:0] UMaxW =
    {{(WideW - OutDataWidth){1'b0}}, {OutDataWidth{1'b1}}};
  localparam logic [OutDataWidth-1:0] SMaxO = {1'b0, {(OutDataWidth - 1){1'b1}}};
  localparam logic [OutDataWidth-1:0] SMinO = {1'b1, {(OutDataWidth - 1){1'b0}}};
  localparam logic [OutDataWidth-1:0] UMaxO = {OutDataWidth{1'b1}};
  localparam logic [OutDataWidth-1:0] UMinO = '0;

  state_e                                           state_q, state_d;
  logic [TileM-1:0][TileN-1:0][OutDataWidth-1:0]    acc_q, acc_d;
  logic [CntWidth-1:0]                              cnt_q, cnt_d;
  logic [CntWidth-1:0]                              steps_q, steps_d;
  logic                                             signed_q, signed_d;
  logic                                             ovf_q, ovf_d;

  logic [TileM-1:0][TileN-1:0][OutDataWidth-1:0]    acc_next;
  logic                                             sat_any;
  logic signed [WideW-1:0]                          sum_w;
  logic [CntWidth-1:0]                              cnt_inc;

  // Operand extension: sign- or zero-extend into the wide signed domain.
  function automatic logic signed [WideW-1:0] ext_in(
    input logic [InDataWidth-1:0] v,
    input logic                   sgn
  );
    return {{(WideW - InDataWidth){sgn & v[InDataWidth-1]}}, v};
  endfunction

  function automatic logic signed [WideW-1:0] ext_acc(
    input logic [OutDataWidth-1:0] v,
    input logic                    sgn
  );
    return {{(WideW - OutDataWidth){sgn & v[OutDataWidth-1]}}, v};
  endfunction

  // Datapath: exact sum of accumulator and all K products, then clamp.
  always_comb begin
    acc_next = '0;
    sat_any  = 1'b0;
    sum_w    = '0;
    for (int m = 0; m < TileM; m++) begin
      for (int n = 0; n < TileN; n++) begin
        sum_w = ext_acc(acc_q[m][n], signed_q);
        for (int k = 0; k < TileK; k++) begin
          sum_w = sum_w + ext_in(a_data_i[m][k], signed_q) * ext_in(b_data_i[k][n], signed_q);
        end
        acc_next[m][n] = sum_w[OutDataWidth-1:0];
        if (signed_q) begin
          if (sum_w > SMaxW) begin
            acc_next[m][n] = SMaxO;
            sat_any        = 1'b1;
          end else if (sum_w < SMinW) begin
            acc_next[m][n] = SMinO;
            sat_any        = 1'b1;
          end
        end else begin
          if (sum_w > UMaxW) begin
            acc_next[m][n] = UMaxO;
            sat_any        = 1'b1;
          end else if (sum_w[WideW-1]) begin
            acc_next[m][n] = UMinO;
            sat_any        = 1'b1;
          end
        end
      end
    end
  end

  assign cnt_inc = cnt_q + 1'b1;

  // FSM next-state and register updates.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    steps_d  = steps_q;
    signed_d = signed_q;
    ovf_d    = ovf_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          steps_d  = num_steps_i;
          signed_d = signed_i;
          acc_d    = '0;
          ovf_d    = 1'b0;
          cnt_d    = '0;
          state_d  = (num_steps_i == '0) ? StDone : StAcc;
        end
      end
      StAcc: begin
        if (in_valid_i) begin
          acc_d = acc_next;
          ovf_d = ovf_q | sat_any;
          cnt_d = cnt_inc;
          // The beat that brings the count to num_steps finishes the tile.
          if (cnt_inc == steps_q) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (c_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      cnt_q    <= '0;
      steps_q  <= '0;
      signed_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      steps_q  <= steps_d;
      signed_q <= signed_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready_o  = (state_q == StAcc);
  assign c_valid_o   = (state_q == StDone);
  assign busy_o      = (state_q != StIdle);
  assign c_data_o    = acc_q;
  assign overflow_o  = ovf_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/gemm_tile_mac.md
GEMM_TILE_MAC -- requirements
Module: gemm_tile_mac

Interface
REQ-001 SHALL have parameter InDataWidth, default 8, the operand element width.
REQ-002 SHALL have parameter OutDataWidth, default 32, the accumulator/result element width (OutDataWidth >= 2*InDataWidth).
REQ-003 SHALL have parameter TileM, default 4, the rows of A and C.
REQ-004 SHALL have parameter TileN, default 4, the columns of B and C.
REQ-005 SHALL have parameter TileK, default 4, the inner dimension consumed per accepted beat.
REQ-006 SHALL have parameter CntWidth, default 16, the width of the step counter.
REQ-007 SHALL have port clk_i  in  1  the single clock; all state updates on its rising edge.
REQ-008 SHALL have port rst_i  in  1  the reset, synchronous and active-high.
REQ-009 SHALL have port start_i  in  1  the tile start request, sampled in IDLE only.
REQ-010 SHALL have port num_steps_i  in  CntWidth  the number of K-beats to accumulate, latched on start.
REQ-011 SHALL have port signed_i  in  1  the operand/saturation mode (1 signed, 0 unsigned), latched on start.
REQ-012 SHALL have port in_valid_i  in  1  the A/B beat valid.
REQ-013 SHALL have port in_ready_o  out  1  the beat ready.
REQ-014 SHALL have port a_data_i  in  [TileM][TileK][InDataWidth]  the A sub-tile.
REQ-015 SHALL have port b_data_i  in  [TileK][TileN][InDataWidth]  the B sub-tile.
REQ-016 SHALL have port c_valid_o  out  1  the result valid.
REQ-017 SHALL have port c_ready_i  in  1  the result consumer ready.
REQ-018 SHALL have port c_data_o  out  [TileM][TileN][OutDataWidth]  the accumulator contents.
REQ-019 SHALL have port busy_o  out  1  the flag that is high whenever state != IDLE.
REQ-020 SHALL have port overflow_o  out  1  the sticky per-tile saturation flag.

Function
REQ-021 SHALL implement FSM states IDLE, ACC, DONE.
REQ-022 In IDLE, start_i=1 SHALL latch num_steps_i/signed_i, zero all accumulators, clear overflow_o, clear the step counter, and go to ACC (num_steps_i>0) or DONE (num_steps_i==0) next cycle.
REQ-023 start_i outside IDLE SHALL be ignored.
REQ-024 in_ready_o SHALL be 1 exactly in ACC.
REQ-025 A beat SHALL be accepted when in_valid_i & in_ready_o; on acceptance every C[m][n] SHALL update next edge to sat(C[m][n] + sum_k A[m][k]*B[k][n]).
REQ-026 Products SHALL be full 2*InDataWidth wide, sign- or zero-extended per latched mode; the K-sum and the add SHALL be computed without loss before saturation.
REQ-027 sat() SHALL clamp to [-2^(OutDataWidth-1), 2^(OutDataWidth-1)-1] (signed) or [0, 2^OutDataWidth-1] (unsigned); any clamp SHALL set overflow_o until the next start or reset.
REQ-028 The step counter SHALL increment per accepted beat; acceptance of beat num_steps SHALL move to DONE next edge (result latency 1 cycle from last beat).
REQ-029 ACC SHALL sustain one beat per cycle; in_valid_i low SHALL stall without state change.
REQ-030 In DONE, c_valid_o SHALL be 1 and c_data_o/overflow_o SHALL be held stable; c_valid_o & c_ready_i SHALL return to IDLE next edge.
REQ-031 c_data_o SHALL always reflect the accumulator registers; it is meaningful only while c_valid_o=1.
REQ-032 The accumulator SHALL retain its value in IDLE after handoff until the next start.

Reset
REQ-033 rst_i=1 at a rising edge SHALL force IDLE, zero all accumulators, counter, and overflow_o; c_valid_o, in_ready_o, busy_o SHALL be 0 from that edge.
REQ-034 rst_i SHALL override all other inputs in the same cycle, including mid-ACC and DONE; any partial tile is discarded.

Verification
REQ-035 Defaults, A[i][k]=i+k+1, B[k][j]=k*j+1, num_steps=1, signed -> c_valid_o 1 cycle after beat; C[0][0]=10, C[0][1]=30, C[3][3]=136.
REQ-036 Same data, num_steps=2, with in_valid_i low for 3 cycles between beats -> C[0][0]=20, C[0][1]=60, C[3][3]=272; in_ready_o stays 1 during the gap.
REQ-037 OutDataWidth=16, signed, A=B=all -128, num_steps=1 -> every C=32767, overflow_o=1; unsigned, A=B=all 255 -> every C=65535, overflow_o=1.
REQ-038 c_ready_i held low 5 cycles in DONE -> c_valid_o stays 1, c_data_o unchanged, in_ready_o=0, start_i ignored; c_ready_i=1 -> IDLE next edge.
REQ-039 num_steps_i=0 -> DONE one cycle after start, all C=0, no beat accepted.
REQ-040 rst_i asserted after 1 of 3 beats -> IDLE, busy_o=0, all C=0 next edge; new tile afterwards yields REQ-035 values.
